// File: rtl/fir_decim_pkg.sv
// ---------------------------------------------------------------------------
// fir_decim_pkg
// Shared definitions for the decimating FIR filter:
//   - state_t      : controller states (S_FILL, S_MAC, S_WRITE)
//   - DEF_*        : default DATA_WIDTH / TAPS / DECIM / BITS values
//   - H_COEF       : lowpass coefficient table h[0..31], fixed point with
//                    DEF_BITS fraction bits (1024 == 1.0)
//   - coef_at()    : bounds-safe coefficient lookup (0 outside the table)
// ---------------------------------------------------------------------------
package fir_decim_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAPS       = 32;
    localparam int DEF_DECIM      = 8;
    localparam int DEF_BITS       = 10;

    localparam int COEF_COUNT     = 32;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Symmetric lowpass; small negative side lobes at both ends.
    localparam logic signed [31:0] H_COEF [0:COEF_COUNT-1] = '{
        -32'sd4,  -32'sd7,  -32'sd9,  -32'sd8,  -32'sd2,   32'sd9,  32'sd25,  32'sd44,
         32'sd63,  32'sd80,  32'sd93, 32'sd101, 32'sd104, 32'sd106, 32'sd107, 32'sd108,
         32'sd108, 32'sd107, 32'sd106, 32'sd104, 32'sd101, 32'sd93,  32'sd80,  32'sd63,
         32'sd44,  32'sd25,  32'sd9,  -32'sd2,  -32'sd8,  -32'sd9,  -32'sd7,  -32'sd4
    };

    // Taps beyond the table contribute nothing, so a larger TAPS still
    // elaborates cleanly.
    function automatic logic signed [31:0] coef_at(input int k);
        logic signed [31:0] c;
        c = '0;
        if (k >= 0 && k < COEF_COUNT) begin
            c = H_COEF[k];
        end
        return c;
    endfunction

endpackage

// File: rtl/fir_decim_mac.sv
// ---------------------------------------------------------------------------
// fir_mac
// Multiply / dequantize / accumulate datapath for fir_decim.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : zero the accumulator on this edge (start of a new output)
//   en           : add dq(coef*sample) to the accumulator on this edge
//   coef, sample : current tap operands (two's complement)
//   acc_sum      : accumulator plus the current term (combinational), so the
//                  controller can capture the finished sum on the last tap
// ---------------------------------------------------------------------------
module fir_mac
    import fir_decim_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BITS       = DEF_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] coef,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] acc_sum
);

    // 2^BITS - 1: bias that turns the floor of an arithmetic shift into a
    // truncation toward zero for negative products.
    localparam logic signed [DATA_WIDTH-1:0] ROUND_BIAS =
        DATA_WIDTH'((64'sd1 <<< BITS) - 64'sd1);

    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] acc_d;
    logic signed [DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0] dq;
    logic signed [DATA_WIDTH-1:0] sum;

    always_comb begin
        // Result width equals operand width, so only the low DATA_WIDTH
        // bits of the signed product are kept.
        prod = $signed(coef) * $signed(sample);
        if (prod[DATA_WIDTH-1]) begin
            dq = (prod + ROUND_BIAS) >>> BITS;
        end else begin
            dq = prod >>> BITS;
        end
        sum = acc_q + dq;   // wraps modulo 2^DATA_WIDTH

        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_sum = sum;

endmodule

// File: rtl/fir_decim.sv
// ---------------------------------------------------------------------------
// fir_decim
// Decimating FIR filter between two first-word-fall-through FIFOs.
// Pops DECIM samples into a TAPS-deep history, then spends TAPS cycles
// multiply-accumulating h[k]*x[k] (x[0] = newest), then pushes one result.
//   clock, reset : clock and asynchronous active-high reset
//   in_dout      : head sample of the upstream FIFO (valid when !in_empty)
//   in_empty     : upstream FIFO empty flag
//   in_rd_en     : upstream pop strobe (combinational in S_FILL)
//   out_din      : registered filter result
//   out_full     : downstream FIFO full flag
//   out_wr_en    : downstream push strobe (combinational in S_WRITE)
// ---------------------------------------------------------------------------
module fir_decim
    import fir_decim_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int DECIM      = DEF_DECIM,
    parameter int BITS       = DEF_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    localparam int TAP_W  = (TAPS > 1)  ? $clog2(TAPS)  : 1;
    localparam int FILL_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DECIM - 1);

    state_t                state_q, state_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [TAP_W-1:0]      tap_q, tap_d;
    logic [DATA_WIDTH-1:0] out_din_q, out_din_d;
    logic                  run_q;

    logic [DATA_WIDTH-1:0] x_q [0:TAPS-1];
    logic [DATA_WIDTH-1:0] x_d [0:TAPS-1];

    logic                  pop;
    logic                  wr;
    logic                  mac_clear;
    logic                  mac_en;
    logic [DATA_WIDTH-1:0] cur_coef;
    logic [DATA_WIDTH-1:0] cur_sample;
    logic [DATA_WIDTH-1:0] mac_sum;

    // History shift register: a pop inserts at x[0] and ages every slot.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign x_d[gi] = pop ? in_dout : x_q[gi];
            end else begin : g_tail
                assign x_d[gi] = pop ? x_q[gi-1] : x_q[gi];
            end
        end
    endgenerate

    // Tap operands for the current MAC cycle.
    always_comb begin
        cur_coef   = DATA_WIDTH'(coef_at(int'(tap_q)));
        cur_sample = x_q[tap_q];
    end

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .BITS       (BITS)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .clear   (mac_clear),
        .en      (mac_en),
        .coef    (cur_coef),
        .sample  (cur_sample),
        .acc_sum (mac_sum)
    );

    // Controller next-state and strobes.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        tap_d     = tap_q;
        out_din_d = out_din_q;
        pop       = 1'b0;
        wr        = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;

        case (state_q)
            S_FILL: begin
                // run_q keeps the pop strobe low in the cycle reset releases.
                if (run_q && !in_empty) begin
                    pop = 1'b1;
                    if (fill_q == FILL_LAST) begin
                        fill_d    = '0;
                        tap_d     = '0;
                        mac_clear = 1'b1;
                        state_d   = S_MAC;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (tap_q == TAP_LAST) begin
                    // Capture the sum including this last term directly.
                    out_din_d = mac_sum;
                    tap_d     = '0;
                    state_d   = S_WRITE;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    wr      = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FILL;
            fill_q    <= '0;
            tap_q     <= '0;
            out_din_q <= '0;
            run_q     <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            tap_q     <= tap_d;
            out_din_q <= out_din_d;
            run_q     <= 1'b1;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    assign in_rd_en  = pop;
    assign out_wr_en = wr;
    assign out_din   = out_din_q;

endmodule

// File: tb/tb_fir_decim.sv
module tb_fir_decim;
    import fir_decim_pkg::*;

    localparam int NTAPS  = 32;
    localparam int NDECIM = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_dout = '0;
    logic        in_empty = 1'b1;
    logic        out_full = 1'b0;
    logic        in_rd_en;
    logic        out_wr_en;
    logic [31:0] out_din;

    fir_decim #(
        .DATA_WIDTH (32),
        .TAPS       (NTAPS),
        .DECIM      (NDECIM),
        .BITS       (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_din   (out_din),
        .out_full  (out_full),
        .out_wr_en (out_wr_en)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] src_q [$];     // upstream FIFO contents
    logic [31:0] got_q [$];     // results written by the DUT
    int          exp_q [$];     // reference results
    int          wr_cyc_q [$];
    int          lat_q [$];
    int          hist [0:NTAPS-1];
    int          pops_mod = 0;
    int          pops_total = 0;
    int          cyc = 0;
    int          last_dec_pop_cyc = 0;
    int          rd_viol = 0;
    bit          rand_empty = 1'b0;
    logic [31:0] a_in  [0:799];
    logic [31:0] a_out [0:99];

    // Reference: sum over k of (h[k]*x[k] wrapped to 32 bits) / 2^10,
    // integer division truncating toward zero, accumulated with 32-bit wrap.
    function automatic int model_out();
        int acc;
        int p;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            p = int'(H_COEF[k]) * hist[k];
            acc += p / 1024;
        end
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Upstream FWFT FIFO: head presented on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            in_empty = (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 1));
            in_dout  = (src_q.size() != 0) ? src_q[0] : 32'h0;
        end
    end

    // Observe pops/writes and run the reference model.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) hist[k] = 0;
            pops_mod = 0;
            while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        end else begin
            cyc++;
            if (in_rd_en && in_empty) rd_viol++;
            if (out_wr_en) begin
                got_q.push_back(out_din);
                wr_cyc_q.push_back(cyc);
                lat_q.push_back(cyc - last_dec_pop_cyc);
            end
            if (in_rd_en) begin
                if (src_q.size() == 0) begin
                    rd_viol++;
                end else begin
                    for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                    hist[0] = int'(src_q.pop_front());
                    pops_mod++;
                    pops_total++;
                    if (pops_mod == NDECIM) begin
                        pops_mod = 0;
                        exp_q.push_back(model_out());
                        last_dec_pop_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic wait_writes(input int n, input int budget);
        int t;
        t = 0;
        while (got_q.size() < n && t < budget) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        int t;
        t = 0;
        while (pops_total < target && t < budget) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        wr_cyc_q.delete();
        lat_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int hold_viol;
        logic [31:0] held;

        // ---- reset behaviour, with a non-empty upstream FIFO ----
        for (int i = 0; i < 800; i++) begin
            a_in[i] = $urandom();
            src_q.push_back(a_in[i]);
        end
        repeat (3) @(negedge clock);
        #1;
        check("reset_rd_en", {31'b0, in_rd_en}, 32'd0);
        check("reset_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("reset_out_din", out_din, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("release_cycle_rd_en", {31'b0, in_rd_en}, 32'd0);

        // ---- 800 random samples, FIFO never empty: 100 results ----
        wait_writes(100, 6000);
        check("a_count", got_q.size(), 32'd100);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("a_out%0d", i), got_q[i], exp_q[i]);
            a_out[i] = got_q[i];
        end
        check("a_latency", lat_q[0], NTAPS + 1);
        check("a_period", wr_cyc_q[1] - wr_cyc_q[0], NDECIM + NTAPS + 1);

        // ---- impulse 0x400 aligned so h[0], h[8], h[16], h[24] appear ----
        do_reset();
        for (int i = 0; i < 40; i++) src_q.push_back((i == 7) ? 32'h400 : 32'h0);
        wait_writes(5, 600);
        check("imp_count", got_q.size(), 32'd5);
        check("imp_h0", got_q[0], H_COEF[0]);
        check("imp_h8", got_q[1], H_COEF[8]);
        check("imp_h16", got_q[2], H_COEF[16]);
        check("imp_h24", got_q[3], H_COEF[24]);
        check("imp_tail", got_q[4], 32'd0);

        // ---- downstream full for 50 cycles after S_WRITE is entered ----
        do_reset();
        out_full = 1'b1;
        target = pops_total + NDECIM;
        for (int i = 0; i < NDECIM; i++) src_q.push_back($urandom());
        wait_pops(target, 200);
        for (int i = 0; i < NDECIM; i++) src_q.push_back($urandom());
        repeat (NTAPS) @(negedge clock);
        held = out_din;
        check("full_out_din", held, exp_q[0]);
        hold_viol = 0;
        repeat (50) begin
            @(negedge clock);
            if (out_wr_en !== 1'b0 || out_din !== held) hold_viol++;
        end
        check("full_hold", hold_viol, 32'd0);
        check("full_no_pop", src_q.size(), NDECIM);
        check("full_no_write", got_q.size(), 32'd0);
        out_full = 1'b0;
        repeat (3) @(negedge clock);
        check("full_single_write", got_q.size(), 32'd1);
        check("full_write_value", got_q[0], held);
        wait_writes(2, 200);
        check("full_next_value", got_q[1], exp_q[1]);

        // ---- random 50% empty: same results as the never-empty run ----
        do_reset();
        rd_viol = 0;
        rand_empty = 1'b1;
        for (int i = 0; i < 800; i++) src_q.push_back(a_in[i]);
        wait_writes(100, 20000);
        rand_empty = 1'b0;
        check("d_count", got_q.size(), 32'd100);
        for (int i = 0; i < 100; i++) begin
            check($sformatf("d_out%0d", i), got_q[i], a_out[i]);
        end
        check("d_rd_when_empty", rd_viol, 32'd0);

        // ---- reset in MAC cycle 10 abandons the result ----
        do_reset();
        target = pops_total + NDECIM;
        for (int i = 0; i < NDECIM; i++) src_q.push_back($urandom());
        wait_pops(target, 200);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("e_no_write", got_q.size(), 32'd0);
        for (int i = 0; i < NDECIM; i++) src_q.push_back($urandom());
        wait_writes(1, 200);
        check("e_count", got_q.size(), 32'd1);
        check("e_fresh_value", got_q[0], exp_q[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, sample and result width (signed two's complement).
REQ-002 The block SHALL have parameter TAPS, default 32, number of filter coefficients.
REQ-003 The block SHALL have parameter DECIM, default 8, input samples consumed per output produced.
REQ-004 The block SHALL have parameter BITS, default 10, fixed-point fraction bits used for dequantization.
REQ-005 The block SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 The block SHALL have port in_dout, input, DATA_WIDTH, head-of-queue sample from the upstream first-word-fall-through FIFO, valid whenever in_empty=0.
REQ-008 The block SHALL have port in_empty, input, 1, upstream FIFO empty flag.
REQ-009 The block SHALL have port in_rd_en, output, 1, pop strobe to the upstream FIFO.
REQ-010 The block SHALL have port out_din, output, DATA_WIDTH, filtered result to the downstream FIFO.
REQ-011 The block SHALL have port out_full, input, 1, downstream FIFO full flag.
REQ-012 The block SHALL have port out_wr_en, output, 1, push strobe to the downstream FIFO.

Function
REQ-013 The block SHALL implement an FSM with states S_FILL, S_MAC and S_WRITE.
REQ-014 In S_FILL, in_rd_en SHALL equal (in_empty==0), combinationally; in_rd_en SHALL be 0 in every other state.
REQ-015 On each pop, in_dout SHALL enter history slot x[0], and slots x[k] SHALL shift to x[k+1]; the oldest sample is discarded.
REQ-016 A fill counter SHALL count pops; on the DECIM-th pop the FSM SHALL go to S_MAC and the counter SHALL clear.
REQ-017 S_MAC SHALL last exactly TAPS cycles; cycle k SHALL add dq(h[k]*x[k]) to the accumulator, where the accumulator was cleared on entry.
REQ-018 Product h[k]*x[k] SHALL be the low DATA_WIDTH bits of the signed multiplication.
REQ-019 dq(p) SHALL be p divided by 2^BITS, truncated toward zero (arithmetic shift with correction for negative p).
REQ-020 Accumulation SHALL wrap modulo 2^DATA_WIDTH with no saturation.
REQ-021 After the final MAC cycle, the accumulator value SHALL be registered onto out_din and the FSM SHALL enter S_WRITE.
REQ-022 In S_WRITE, out_wr_en SHALL equal (out_full==0); when it is 1 the FSM SHALL return to S_FILL in the same edge.
REQ-023 While out_full=1, S_WRITE SHALL hold; out_din SHALL stay stable and no input SHALL be popped.
REQ-024 in_empty=1 during S_FILL SHALL stall the block without loss or duplication of samples.
REQ-025 Latency from the DECIM-th pop edge to the first possible out_wr_en SHALL be TAPS+1 cycles.
REQ-026 Steady-state throughput SHALL be one output per DECIM+TAPS+1 cycles.

Reset
REQ-027 Reset SHALL force state S_FILL, fill counter 0, accumulator 0, all history slots 0 and out_din 0, independent of clock.
REQ-028 During reset and in the cycle it deasserts, in_rd_en and out_wr_en SHALL be 0.
REQ-029 Reset asserted in S_MAC or S_WRITE SHALL abandon the partial result with no out_wr_en pulse.

Structure
REQ-030 A shared package SHALL hold the state enum, the default DATA_WIDTH/TAPS/DECIM/BITS constants and the coefficient array h[0..TAPS-1].
REQ-031 The dequantize-and-accumulate step SHALL be one sub-module, fir_mac, holding the accumulator and the multiply and dq logic.

Verification
REQ-032 800 samples of the demodulated stream are written with upstream FIFO never empty -> exactly 100 outputs are produced, bit-exact to the golden lowpass file.
REQ-033 An impulse of 0x00000400 followed by 31 zeros -> the outputs equal h[0], h[8], h[16], h[24] (dq of h*1024 = h), then 0.
REQ-034 out_full is held 1 for 50 cycles when S_WRITE is entered -> out_wr_en stays 0 and out_din stays constant; a single write follows deassertion.
REQ-035 in_empty is toggled randomly at 50% -> the output sequence is identical to that of REQ-032, and in_rd_en is never 1 when in_empty=1.
REQ-036 reset is pulsed in S_MAC cycle 10 -> no write is issued; the history is all zero, and the next 8 inputs produce an output computed from those 8 samples only.
